// File: rtl/pio_tx_sched_if.sv
// Bundles the per-source request lanes, the TX port and the scheduler status outputs.
// The master modport is the scheduler's view; the slave modport is the surrounding logic.
interface pio_tx_sched_if #(
    parameter int unsigned N  = 6,
    parameter int unsigned DW = 256
) ();
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_last;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic            tx_valid;
    logic            tx_last;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic            err_len;
    logic            pe;

    modport master (
        input  src_valid, src_last, src_data, tx_ready,
        output src_ready, tx_valid, tx_last, tx_data, grant, busy, err_len, pe
    );

    modport slave (
        output src_valid, src_last, src_data, tx_ready,
        input  src_ready, tx_valid, tx_last, tx_data, grant, busy, err_len, pe
    );
endinterface

// File: rtl/pio_tx_sched.sv
// Packet-level round-robin scheduler/mux sharing the PIO TX stream between N sources.
// Optional arbitration-state parity check is enabled by defining PIO_TX_SCHED_PARITY_EN.
module pio_tx_sched #(
    parameter int unsigned N         = 6,
    parameter int unsigned DW        = 256,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic           user_clk,
    input  logic           reset,
    pio_tx_sched_if.master bus_io
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);
    localparam logic [IW-1:0] LastIdxRst = IW'(N - 1);
    localparam logic [CW-1:0] CntMax     = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CntWarn    = CW'(MAX_BEATS - 1);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_len_q, err_len_d;

    logic          hi_found, lo_found;
    logic [IW-1:0] hi_idx, lo_idx, win_idx;
    logic [IW-1:0] g_idx;
    logic          tx_valid, tx_last, accept;
    logic [DW-1:0] tx_data;

    // Round-robin pick: first requester above last_idx, else first requester overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus_io.src_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
            if (bus_io.src_valid[i] && (i > 32'(last_idx_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // grant_q is all-zero outside XFER, so the mux naturally yields zeros when idle.
    always_comb begin
        g_idx    = '0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                g_idx    = IW'(i);
                tx_valid = bus_io.src_valid[i];
                tx_last  = bus_io.src_last[i];
                tx_data  = bus_io.src_data[i*DW +: DW];
            end
        end
    end

    assign accept = (state_q == StXfer) && tx_valid && bus_io.tx_ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        err_len_d  = err_len_q;
        unique case (state_q)
            StIdle: begin
                if (|bus_io.src_valid) begin
                    grant_d = N'(1) << win_idx;
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (tx_last) begin
                        last_idx_d = g_idx;
                        grant_d    = '0;
                        state_d    = StIdle;
                    end else if (cnt_q == CntWarn) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            last_idx_q <= LastIdxRst;
            cnt_q      <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            err_len_q  <= err_len_d;
        end
    end

`ifdef PIO_TX_SCHED_PARITY_EN
    logic par_q, par_d;

    // Parity predicted from next-state values so a flipped register bit is caught.
    assign par_d = ^{grant_d, last_idx_d};

    always_ff @(posedge user_clk) begin
        if (reset) begin
            par_q <= ^LastIdxRst;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus_io.pe = ^{grant_q, last_idx_q, par_q};
`else
    assign bus_io.pe = 1'b0;
`endif

    assign bus_io.grant     = grant_q;
    assign bus_io.busy      = (state_q == StXfer);
    assign bus_io.tx_valid  = tx_valid;
    assign bus_io.tx_last   = tx_last;
    assign bus_io.tx_data   = tx_data;
    assign bus_io.src_ready = grant_q & {N{bus_io.tx_ready && (state_q == StXfer)}};
    assign bus_io.err_len   = err_len_q;
endmodule

// File: doc/pio_tx_sched.md
# pio_tx_sched

Packet-level round-robin scheduler and multiplexer that shares the single PIO TX stream toward the PCIe core between N TLP sources. It picks the next source fairly, holds the grant for a whole packet (first beat to `last`), and steers data/valid/last/ready between the granted source and the TX port. It sits between the PIO request generators and the PCIe TX interface. An optional parity checker covers its arbitration state.

## Interface
Parameters:
- `N`, 6, number of requesting sources (2..16)
- `DW`, 256, data width per beat
- `MAX_BEATS`, 16, packet length limit in beats (power of 2 not required, ≥2)

Ports:
- `user_clk` in 1: single clock, all logic on its rising edge
- `reset` in 1: synchronous, active-high reset
- `src_valid` in N: per-source beat valid
- `src_last` in N: per-source last beat of packet
- `src_data` in N*DW: source i occupies bits [i*DW +: DW]
- `src_ready` out N: per-source beat accept
- `tx_valid` out 1: beat valid to TX port
- `tx_last` out 1: last beat to TX port
- `tx_data` out DW: beat data to TX port
- `tx_ready` in 1: TX port accepts beat
- `grant` out N: one-hot registered grant, all-zero when idle
- `busy` out 1: high in XFER
- `err_len` out 1: sticky, packet exceeded MAX_BEATS
- `pe` out 1: arbitration-state parity error (see Configuration)

## Operation
- FSM states: IDLE, XFER.
- IDLE: `grant`=0, all `src_ready`=0, `tx_valid`=0. If any `src_valid`, register the winner into `grant`, clear the beat counter, and go to XFER.
- Winner selection: lowest index i with `src_valid[i]` and i > `last_idx`. If there is none, the lowest index with `src_valid[i]`. `last_idx` resets to N-1, so source 0 has first priority.
- XFER with granted index g:
  - `tx_valid`=`src_valid[g]`, `tx_last`=`src_last[g]`, `tx_data`=`src_data[g]`.
  - `src_ready[g]`=`tx_ready`. All other `src_ready` bits are 0.
  - These outputs are combinational from the registered `grant`.
- Beat accepted when `tx_valid & tx_ready`. The beat counter (width clog2(MAX_BEATS+1)) increments on each accepted beat.
- Accepted beat with `tx_last`=1: `last_idx`<=g, `grant`<=0, go to IDLE. This forces one bubble cycle between packets, even from the same source.
- Accepted non-last beat when counter == MAX_BEATS-1: set `err_len`. It stays set until `reset`. The transfer continues until `last`, with no truncation. The counter saturates at MAX_BEATS.
- Requests from other sources during XFER are ignored. Grant changes only at a packet boundary.
- A source that drops `src_valid` mid-packet stalls the TX port. The grant is held.
- `tx_ready` low holds everything. The counter does not advance.
- Single requester: it is re-granted after each one-cycle IDLE bubble.

## Timing
- Reset values: `grant`=0, `busy`=0, `tx_valid`=0, `tx_last`=0, `tx_data`=0, `src_ready`=0, `err_len`=0, `pe`=0, `last_idx`=N-1, state IDLE.
- Reset applied mid-packet drops the grant at that edge. The partial packet is abandoned and the source must restart it.
- Grant latency: `src_valid` sampled high in IDLE at edge k gives `grant`/`busy` high after edge k. The first beat can be accepted in cycle k+1.
- Throughput: a packet of L beats with continuous valid/ready occupies L+1 cycles (L in XFER plus 1 IDLE).
- `tx_data` is 0 whenever `grant`=0.

## Configuration
- `PIO_TX_SCHED_PARITY_EN` defined:
  - A parity bit is stored alongside {`grant`, `last_idx`}. It is predicted from the next-state values, not recomputed from the registers.
  - `pe` = XOR over {`grant`, `last_idx`, parity bit} ≠ expected even parity. `pe` is combinational from the registers and 0 after reset.
- Not defined: no parity register exists and `pe` is tied to 0.

## Test plan
- N=6, sources 1 and 4 both request 2-beat packets from reset, `tx_ready`=1 -> grant 0b000010 first, then 0b010000, with one idle cycle between. `tx_data` matches each source's beats in order.
- All 6 sources request 1-beat packets continuously -> grant order 0,1,2,3,4,5,0. Each grant lasts 1 cycle followed by 1 idle cycle.
- Source 2 packet of 3 beats while `tx_ready` toggles 1,0,1,0,1 -> exactly 3 accepted beats. `src_ready[2]` mirrors `tx_ready`. Other sources are never readied.
- MAX_BEATS=16, source 0 sends 18 beats with last on beat 18 -> `err_len` rises after the 16th accepted beat. All 18 beats pass. The flag stays high after the packet.
- `reset` asserted during beat 2 of a 4-beat packet from source 3 -> next cycle `grant`=0 and `tx_valid`=0. After release the arbitration restarts from source 0 priority.
- With `PIO_TX_SCHED_PARITY_EN`, force-flip one `grant` register bit -> `pe`=1 in the same cycle. Without the macro, `pe` stays 0.
